// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state encoding,
// default operand width and derived product width.
package mult_pkg;

   // FSM state encoding, shared with the multiplier control FSM
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mult_state_t;

   localparam int unsigned MULT_WIDTH = 32;
   localparam int unsigned PROD_W     = 2 * MULT_WIDTH;

   // Product width for an arbitrary operand width
   function automatic int unsigned prod_width(input int unsigned w);
      return 2 * w;
   endfunction

endpackage

// File: rtl/mult_result_hold.sv
// Result holding register for the shift-add multiplier.
// Captures the product on the rising edge of done_flag and holds it with a
// valid/ack handshake toward the downstream consumer.
module mult_result_hold
   import mult_pkg::*;
#(
   parameter int unsigned DATA_W = PROD_W
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              done_flag,
   input  logic              ack,
   input  logic [DATA_W-1:0] prod_in,
   output logic [DATA_W-1:0] result,
   output logic              result_valid
);

   logic done_q;
   logic capture;

   // Single capture per done_flag assertion, however long it stays high
   always_comb begin
      capture = done_flag & ~done_q;
   end

   // Edge detect, result register and valid/ack handshake; capture beats ack
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         done_q       <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
      end else begin
         done_q <= done_flag;
         if (capture) begin
            result       <= prod_in;
            result_valid <= 1'b1;
         end else if (ack) begin
            result_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/mult_shift_add_datapath.sv
// Datapath for the sequential shift-add multiplier: operand shift registers,
// product accumulator and step counter, driven by the control FSM selects.
// Optional feature: define MULT_EARLY_TERM_EN to enable the b_zero comparator
// used by the FSM to leave CALC early.
module mult_shift_add_datapath
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = MULT_WIDTH
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic [WIDTH-1:0]     operand_a,
   input  logic [WIDTH-1:0]     operand_b,
   input  logic                 a_sel,
   input  logic                 b_sel,
   input  logic                 prod_sel,
   input  logic                 add_sel,
   input  logic                 done_flag,
   input  logic                 ack,
   output logic                 b_lsb,
   output logic                 step_done,
   output logic                 b_zero,
   output logic [2*WIDTH-1:0]   result,
   output logic                 result_valid
);

   localparam int unsigned           PW      = prod_width(WIDTH);
   localparam int unsigned           CNT_W   = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(WIDTH);

   logic [PW-1:0]    reg_a;
   logic [WIDTH-1:0] reg_b;
   logic [PW-1:0]    reg_prod;
   logic [CNT_W-1:0] step_cnt;

   // Multiplicand: load zero-extended, then shift left once per step
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)      reg_a <= '0;
      else if (!a_sel) reg_a <= PW'(operand_a);
      else            reg_a <= {reg_a[PW-2:0], 1'b0};
   end

   // Multiplier: load, then shift right once per step exposing the next bit
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)      reg_b <= '0;
      else if (!b_sel) reg_b <= operand_b;
      else            reg_b <= {1'b0, reg_b[WIDTH-1:1]};
   end

   // Accumulator: adds the pre-shift multiplicand on the same edge as the shift
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)                    reg_prod <= '0;
      else if (!prod_sel)           reg_prod <= '0;
      else if (add_sel)             reg_prod <= reg_prod + reg_a;
   end

   // Step counter: cleared on load, saturates at WIDTH
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)                        step_cnt <= '0;
      else if (!a_sel)                  step_cnt <= '0;
      else if (step_cnt < CNT_MAX)      step_cnt <= step_cnt + 1'b1;
   end

   // Status back to the FSM
   always_comb begin
      b_lsb     = reg_b[0];
      step_done = (step_cnt == CNT_MAX);
   end

`ifdef MULT_EARLY_TERM_EN
   assign b_zero = (reg_b == '0);
`else
   assign b_zero = 1'b0;
`endif

   mult_result_hold #(
      .DATA_W (PW)
   ) u_result_hold (
      .Clock        (Clock),
      .Reset        (Reset),
      .done_flag    (done_flag),
      .ack          (ack),
      .prod_in      (reg_prod),
      .result       (result),
      .result_valid (result_valid)
   );

endmodule

// File: tb/tb_mult_shift_add_datapath.sv
// Directed self-checking bench for mult_shift_add_datapath (WIDTH=32).
module tb_mult_shift_add_datapath;

   logic        Clock;
   logic        Reset;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        a_sel;
   logic        b_sel;
   logic        prod_sel;
   logic        add_sel;
   logic        done_flag;
   logic        ack;
   logic        b_lsb;
   logic        step_done;
   logic        b_zero;
   logic [63:0] result;
   logic        result_valid;

   int n_tests = 0;
   int n_fail  = 0;

   mult_shift_add_datapath #(
      .WIDTH (32)
   ) dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .operand_a    (operand_a),
      .operand_b    (operand_b),
      .a_sel        (a_sel),
      .b_sel        (b_sel),
      .prod_sel     (prod_sel),
      .add_sel      (add_sel),
      .done_flag    (done_flag),
      .ack          (ack),
      .b_lsb        (b_lsb),
      .step_done    (step_done),
      .b_zero       (b_zero),
      .result       (result),
      .result_valid (result_valid)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 time unit after it
   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic load_ops(input logic [31:0] a, input logic [31:0] b);
      operand_a = a;
      operand_b = b;
      a_sel     = 1'b0;
      b_sel     = 1'b0;
      prod_sel  = 1'b0;
      add_sel   = 1'b0;
      done_flag = 1'b0;
      step();
   endtask

   // CALC cycles, with add_sel following b_lsb as the FSM would
   task automatic calc_cycles(input int n, output int adds);
      adds     = 0;
      a_sel    = 1'b1;
      b_sel    = 1'b1;
      prod_sel = 1'b1;
      for (int i = 0; i < n; i++) begin
         add_sel = b_lsb;
         if (b_lsb) adds++;
         step();
      end
      add_sel = 1'b0;
   endtask

   task automatic load_and_calc(input string tag, input logic [31:0] a, input logic [31:0] b,
                                output int adds);
      int n1;
      int n2;
      load_ops(a, b);
`ifdef MULT_EARLY_TERM_EN
      check({tag, " b_zero after load"}, {63'd0, b_zero}, {63'd0, (b == 32'd0)});
`else
      check({tag, " b_zero after load"}, {63'd0, b_zero}, 64'd0);
`endif
      calc_cycles(31, n1);
      check({tag, " step_done at 31"}, {63'd0, step_done}, 64'd0);
      calc_cycles(1, n2);
      check({tag, " step_done at 32"}, {63'd0, step_done}, 64'd1);
      adds = n1 + n2;
   endtask

   // Rising done_flag captures the product; then release done_flag
   task automatic capture(input string tag, input logic [63:0] exp);
      done_flag = 1'b1;
      step();
      check({tag, " result_valid"}, {63'd0, result_valid}, 64'd1);
      check({tag, " result"}, result, exp);
      done_flag = 1'b0;
      step();
   endtask

   int adds;

   initial begin
      Reset     = 1'b1;
      operand_a = '0;
      operand_b = '0;
      a_sel     = 1'b0;
      b_sel     = 1'b0;
      prod_sel  = 1'b0;
      add_sel   = 1'b0;
      done_flag = 1'b0;
      ack       = 1'b0;
      step();
      step();
      check("reset b_lsb", {63'd0, b_lsb}, 64'd0);
      check("reset step_done", {63'd0, step_done}, 64'd0);
      check("reset b_zero", {63'd0, b_zero}, 64'd0);
      check("reset result", result, 64'd0);
      check("reset result_valid", {63'd0, result_valid}, 64'd0);
      Reset = 1'b0;
      step();

      // Basic product 3 x 5
      load_and_calc("basic", 32'd3, 32'd5, adds);
      check("basic adds", 64'(adds), 64'd2);
      check("basic reg_prod", dut.reg_prod, 64'd15);
      capture("basic", 64'd15);

      // Reset mid-CALC: load 7 x 9, 5 steps, then async reset between edges
      load_ops(32'd7, 32'd9);
      calc_cycles(5, adds);
      #2;
      Reset = 1'b1;
      #1;
      check("midreset reg_a", dut.reg_a, 64'd0);
      check("midreset reg_b", {32'd0, dut.reg_b}, 64'd0);
      check("midreset reg_prod", dut.reg_prod, 64'd0);
      check("midreset step_cnt", {58'd0, dut.step_cnt}, 64'd0);
      check("midreset result", result, 64'd0);
      check("midreset result_valid", {63'd0, result_valid}, 64'd0);
      a_sel = 1'b0; b_sel = 1'b0; prod_sel = 1'b0;
      step();
      Reset = 1'b0;
      step();
      step();
      check("postreset result_valid", {63'd0, result_valid}, 64'd0);
      check("postreset result", result, 64'd0);

      // Full-scale product
      load_and_calc("full", 32'hFFFF_FFFF, 32'hFFFF_FFFF, adds);
      check("full adds", 64'(adds), 64'd32);
      capture("full", 64'hFFFF_FFFE_0000_0001);

      // Zero multiplier
      load_and_calc("zero", 32'h1234_5678, 32'd0, adds);
      check("zero adds", 64'(adds), 64'd0);
      capture("zero", 64'd0);

      // Clear the pending result before the handshake test
      ack = 1'b1;
      step();
      ack = 1'b0;
      check("pre-hs result_valid", {63'd0, result_valid}, 64'd0);

      // Handshake: done_flag held 10 cycles, ack on cycle 4
      load_and_calc("hs", 32'd6, 32'd7, adds);
      done_flag = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         ack = (i == 4);
         step();
         check($sformatf("hs valid c%0d", i), {63'd0, result_valid}, (i < 4) ? 64'd1 : 64'd0);
         check($sformatf("hs result c%0d", i), result, 64'd42);
      end
      ack = 1'b0;
      done_flag = 1'b0;
      step();

      // Simultaneous capture and ack: capture wins
      load_and_calc("pre", 32'd2, 32'd3, adds);
      capture("pre", 64'd6);
      load_and_calc("sim", 32'd11, 32'd13, adds);
      done_flag = 1'b1;
      ack = 1'b1;
      step();
      check("sim result_valid", {63'd0, result_valid}, 64'd1);
      check("sim result", result, 64'd143);
      done_flag = 1'b0;
      step();
      check("sim ack clears", {63'd0, result_valid}, 64'd0);
      step();
      check("ack idle valid", {63'd0, result_valid}, 64'd0);
      check("ack idle result", result, 64'd143);
      ack = 1'b0;

      // Early termination: b=1 becomes zero after the first step
      load_ops(32'h0000_00A5, 32'h0000_0001);
      calc_cycles(1, adds);
`ifdef MULT_EARLY_TERM_EN
      check("early b_zero", {63'd0, b_zero}, 64'd1);
`else
      check("early b_zero", {63'd0, b_zero}, 64'd0);
`endif
      check("early reg_prod", dut.reg_prod, 64'h0000_00A5);
      check("early step_done", {63'd0, step_done}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
